// File: rtl/bank_read_scheduler.sv
// Read-side scheduler for one packet memory bank: round-robin descriptor grant,
// region-wrapping address walk, and latency-aligned framed TX output.
module bank_read_scheduler #(
  parameter int pDEPTH_RAM   = 4605,
  parameter int pREGION_SIZE = 1535,
  parameter int pRD_LAT      = 2,
  parameter int pADR_W       = $clog2(pDEPTH_RAM)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [2:0]                i_desc_empty,
  input  logic [3*(2*pADR_W+2)-1:0] i_desc_data,
  output logic [2:0]                o_desc_pop,
  input  logic                      i_tx_ready,
  output logic [pADR_W-1:0]         o_adr_out,
  output logic                      o_en_read,
  input  logic [31:0]               i_mem_data,
  output logic [31:0]               o_data,
  output logic                      o_valid,
  output logic                      o_sof,
  output logic                      o_eof,
  output logic [1:0]                o_extra_byte,
  output logic [2:0]                o_rel,
  output logic                      o_busy
);

  localparam int DESC_W = 2*pADR_W+2;
  localparam int CNT_W  = (pRD_LAT > 1) ? $clog2(pRD_LAT) : 1;
  localparam logic [pADR_W-1:0] BASE0   = '0;
  localparam logic [pADR_W-1:0] BASE1   = pADR_W'(pREGION_SIZE);
  localparam logic [pADR_W-1:0] BASE2   = pADR_W'(2*pREGION_SIZE);
  localparam logic [pADR_W-1:0] TOP_OFS = pADR_W'(pREGION_SIZE-1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [1:0]         src;
  logic [pADR_W-1:0]  cur;
  logic [pADR_W-1:0]  end_adr;
  logic [1:0]         extra;
  logic               first;
  logic [CNT_W-1:0]   drain_cnt;
  logic [2:0]         tag_pipe [pRD_LAT];

  logic [2:0]         ready;
  logic [2:0]         rot;
  logic [1:0]         offset;
  logic [1:0]         grant;
  logic               start_go;
  logic [DESC_W-1:0]  sel_desc;
  logic [pADR_W-1:0]  base_adr;
  logic [pADR_W-1:0]  top_adr;
  logic               reading;
  logic               at_end;
  logic [2:0]         tag_now;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign ready = ~i_desc_empty;

  // Rotate the ready vector so bit 0 is the pointer's source, then take the first set bit.
  always_comb begin
    rot = ready;
    case (ptr)
      2'd1:    rot = {ready[0], ready[2], ready[1]};
      2'd2:    rot = {ready[1], ready[0], ready[2]};
      default: rot = ready;
    endcase
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else             offset = 2'd2;
    grant = mod3_add(ptr, offset);
  end

  always_comb begin
    case (grant)
      2'd1:    sel_desc = i_desc_data[DESC_W +: DESC_W];
      2'd2:    sel_desc = i_desc_data[2*DESC_W +: DESC_W];
      default: sel_desc = i_desc_data[0 +: DESC_W];
    endcase
  end

  always_comb begin
    case (src)
      2'd1:    base_adr = BASE1;
      2'd2:    base_adr = BASE2;
      default: base_adr = BASE0;
    endcase
    top_adr = base_adr + TOP_OFS;
  end

  // The pop is combinational so the show-ahead descriptor is latched in the same cycle.
  assign start_go   = i_reset && (state == IDLE) && i_tx_ready && (|ready);
  assign o_desc_pop = start_go ? (3'b001 << grant) : 3'b000;

  assign reading = (state == READ);
  assign at_end  = reading && (cur == end_adr);
  assign tag_now = {reading, reading && first, at_end};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      src       <= 2'd0;
      cur       <= '0;
      end_adr   <= '0;
      extra     <= 2'd0;
      first     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_go) begin
            src     <= grant;
            cur     <= sel_desc[pADR_W-1:0];
            end_adr <= sel_desc[2*pADR_W-1:pADR_W];
            extra   <= sel_desc[DESC_W-1:2*pADR_W];
            ptr     <= mod3_add(grant, 2'd1);
            first   <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          first <= 1'b0;
          cur   <= (cur == top_adr) ? base_adr : cur + 1'b1;
          if (cur == end_adr) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_W'(pRD_LAT-1)) state <= IDLE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags travel alongside the SRAM read so they emerge with the returned word.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < pRD_LAT; i++) tag_pipe[i] <= 3'b000;
    end else begin
      tag_pipe[0] <= tag_now;
      for (int i = 1; i < pRD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign o_en_read    = reading;
  assign o_adr_out    = reading ? cur : '0;
  assign o_rel        = at_end ? (3'b001 << src) : 3'b000;
  assign o_busy       = (state != IDLE);
  assign o_valid      = tag_pipe[pRD_LAT-1][2];
  assign o_sof        = tag_pipe[pRD_LAT-1][1];
  assign o_eof        = tag_pipe[pRD_LAT-1][0];
  assign o_extra_byte = o_eof ? extra : 2'b00;
  assign o_data       = o_valid ? i_mem_data : 32'd0;

endmodule

// File: tb/tb_bank_read_scheduler.sv
// Scoreboard bench for bank_read_scheduler: a cycle-level reference model schedules
// expected grants, reads and TX words; a monitor compares them at each negedge.
module tb_bank_read_scheduler;

  localparam int RS  = 1535;
  localparam int AW  = 13;
  localparam int DW  = 2*AW+2;
  localparam int LAT = 2;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [2:0]      i_desc_empty;
  logic [3*DW-1:0] i_desc_data;
  logic [2:0]      o_desc_pop;
  logic            i_tx_ready;
  logic [AW-1:0]   o_adr_out;
  logic            o_en_read;
  logic [31:0]     i_mem_data;
  logic [31:0]     o_data;
  logic            o_valid, o_sof, o_eof;
  logic [1:0]      o_extra_byte;
  logic [2:0]      o_rel;
  logic            o_busy;

  always #5 i_clk = ~i_clk;

  bank_read_scheduler #(
    .pDEPTH_RAM(4605), .pREGION_SIZE(RS), .pRD_LAT(LAT), .pADR_W(AW)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_desc_empty(i_desc_empty),
    .i_desc_data(i_desc_data), .o_desc_pop(o_desc_pop), .i_tx_ready(i_tx_ready),
    .o_adr_out(o_adr_out), .o_en_read(o_en_read), .i_mem_data(i_mem_data),
    .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_extra_byte(o_extra_byte), .o_rel(o_rel), .o_busy(o_busy)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hA5C3_0000 ^ {19'd0, a} ^ ({19'd0, a} << 17);
  endfunction

  // Bank model: two-cycle read latency
  logic          p1_en = 1'b0, p2_en = 1'b0;
  logic [AW-1:0] p1_adr = '0, p2_adr = '0;
  always @(posedge i_clk) begin
    p1_en  <= o_en_read;
    p1_adr <= o_adr_out;
    p2_en  <= p1_en;
    p2_adr <= p1_adr;
  end
  assign i_mem_data = p2_en ? mem_word(p2_adr) : 32'hDEAD_BEEF;

  typedef struct {
    int cyc; logic [2:0] pop; logic busy; logic en; logic [AW-1:0] adr; logic [2:0] rel;
  } ctrl_t;
  typedef struct { int cyc; logic [AW-1:0] adr; logic [2:0] rel; } rd_t;
  typedef struct { int cyc; logic [31:0] data; logic sof; logic eof; logic [1:0] extra; } word_t;

  ctrl_t ctrl_q[$];
  rd_t   rd_q[$];
  word_t word_q[$];
  logic [DW-1:0] q0[$], q1[$], q2[$];

  int cycle = 0;
  int ptr = 0, allowed = 0, grant_cyc = -1;
  bit pend_v = 0;
  int pend_g = 0;
  int n_cmp = 0, n_err = 0;

  function automatic int qsize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qfront(input int s);
    case (s)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int s, input logic [DW-1:0] d);
    case (s)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic qpop(input int s);
    case (s)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  function automatic logic [DW-1:0] mk_desc(input int s, input int off, input int len, input int ex);
    int st, en;
    st = s*RS + off;
    en = s*RS + ((off + len - 1) % RS);
    return {2'(ex), 13'(en), 13'(st)};
  endfunction

  // Expand a granted descriptor into its read addresses and TX words, stamped with their cycles.
  task automatic schedule(input int g, input logic [DW-1:0] d);
    int st, en, ex, base, a, k;
    bit done;
    rd_t r;
    word_t w;
    st = int'(d[AW-1:0]);
    en = int'(d[2*AW-1:AW]);
    ex = int'(d[DW-1:2*AW]);
    base = g*RS;
    a = st; k = 0; done = 0;
    while (!done && k < RS) begin
      r.cyc = cycle + 1 + k;
      r.adr = AW'(a);
      r.rel = (a == en) ? (3'b001 << g) : 3'b000;
      rd_q.push_back(r);
      w.cyc = cycle + 1 + k + LAT;
      w.data = mem_word(AW'(a));
      w.sof = (k == 0);
      w.eof = (a == en);
      w.extra = (a == en) ? 2'(ex) : 2'b00;
      word_q.push_back(w);
      if (a == en) done = 1;
      else begin
        a = (a == base + RS - 1) ? base : a + 1;
        k++;
      end
    end
    allowed = cycle + (k + 1) + LAT + 1;
    grant_cyc = cycle;
    ptr = (g + 1) % 3;
    pend_v = 1;
    pend_g = g;
  endtask

  task automatic model_step();
    ctrl_t c;
    bit granted;
    c.cyc = cycle; c.pop = 3'b000; c.en = 1'b0; c.adr = '0; c.rel = 3'b000;
    c.busy = (cycle > grant_cyc) && (cycle < allowed);
    granted = 0;
    if (cycle >= allowed && i_tx_ready) begin
      for (int k = 0; k < 3; k++) begin
        if (!granted && qsize((ptr + k) % 3) > 0) begin
          granted = 1;
          c.pop = 3'b001 << ((ptr + k) % 3);
          schedule((ptr + k) % 3, qfront((ptr + k) % 3));
        end
      end
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cycle) begin
      c.en = 1'b1;
      c.adr = rd_q[0].adr;
      c.rel = rd_q[0].rel;
      void'(rd_q.pop_front());
    end
    ctrl_q.push_back(c);
  endtask

  task automatic advance();
    @(posedge i_clk);
    #1;
    cycle++;
    if (pend_v) begin
      qpop(pend_g);
      pend_v = 0;
    end
  endtask

  task automatic settle();
    for (int s = 0; s < 3; s++) begin
      i_desc_empty[s] = (qsize(s) == 0);
      i_desc_data[s*DW +: DW] = (qsize(s) > 0) ? qfront(s) : '0;
    end
    if (i_reset) model_step();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      advance();
      settle();
    end
  endtask

  task automatic flush_model();
    ctrl_q.delete();
    rd_q.delete();
    word_q.delete();
    ptr = 0; allowed = 0; grant_cyc = -1; pend_v = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Monitor: pops the expectations due this cycle and compares them with the DUT.
  initial begin
    ctrl_t c;
    word_t w;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        check("reset_outputs",
              64'({o_desc_pop, o_adr_out, o_en_read, o_data, o_valid, o_sof, o_eof,
                   o_extra_byte, o_rel, o_busy}), 64'd0);
      end else if (ctrl_q.size() > 0 && ctrl_q[0].cyc == cycle) begin
        c = ctrl_q.pop_front();
        check("ctrl {pop,busy,en,adr,rel}",
              64'({o_desc_pop, o_busy, o_en_read, (o_en_read ? o_adr_out : 13'd0), o_rel}),
              64'({c.pop, c.busy, c.en, c.adr, c.rel}));
        if (word_q.size() > 0 && word_q[0].cyc == cycle) begin
          w = word_q.pop_front();
          check("word {valid,sof,eof,extra,data}",
                64'({o_valid, o_sof, o_eof, o_extra_byte, o_data}),
                64'({1'b1, w.sof, w.eof, w.extra, w.data}));
        end else begin
          check("idle {valid,sof,eof,extra}",
                64'({o_valid, o_sof, o_eof, o_extra_byte}), 64'd0);
        end
      end
    end
  end

  initial begin
    int budget;
    i_reset = 1'b0;
    i_tx_ready = 1'b0;
    i_desc_empty = 3'b111;
    i_desc_data = '0;
    run(3);
    advance(); i_reset = 1'b1; settle();
    run(2);

    // Src0 four-word frame
    advance(); qpush(0, mk_desc(0, 10, 4, 2)); i_tx_ready = 1'b1; settle();
    run(12);
    // Src1 wrap 3068,3069,1535,1536
    advance(); qpush(1, mk_desc(1, 1533, 4, 1)); settle();
    run(12);
    // Src2 single word at 3071
    advance(); qpush(2, mk_desc(2, 1, 1, 3)); settle();
    run(10);

    // Round-robin with every FIFO holding two descriptors
    advance(); i_tx_ready = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 2; j++) qpush(s, mk_desc(s, 20 + 10*j, 1 + j + s, s));
    settle();
    run(3);
    advance(); i_tx_ready = 1'b1; settle();
    run(60);

    // Only src1 and src2 ready with pointer back at 0
    advance(); qpush(1, mk_desc(1, 50, 3, 0)); qpush(2, mk_desc(2, 1530, 7, 2)); settle();
    run(30);

    // tx_ready low holds off every grant
    advance(); i_tx_ready = 1'b0; qpush(0, mk_desc(0, 5, 2, 1)); qpush(2, mk_desc(2, 7, 2, 3)); settle();
    run(20);
    advance(); i_tx_ready = 1'b1; settle();
    run(25);

    // Reset during READ of a six-word src0 frame
    advance(); qpush(0, mk_desc(0, 100, 6, 1)); settle();
    run(3);
    advance(); i_reset = 1'b0; flush_model(); settle();
    run(3);
    advance(); qpush(0, mk_desc(0, 200, 3, 2)); qpush(1, mk_desc(1, 300, 2, 1)); i_reset = 1'b1; settle();
    run(25);

    // Randomized traffic
    repeat (2500) begin
      advance();
      if ($urandom_range(0, 3) == 0) begin
        int s, off;
        s = $urandom_range(0, 2);
        off = ($urandom_range(0, 3) == 0) ? RS - $urandom_range(1, 6) : $urandom_range(0, RS-1);
        if (qsize(s) < 4) qpush(s, mk_desc(s, off, $urandom_range(1, 8), $urandom_range(0, 3)));
      end
      i_tx_ready = ($urandom_range(0, 9) != 0);
      settle();
    end

    advance(); i_tx_ready = 1'b1; settle();
    budget = 2000;
    while ((qsize(0) + qsize(1) + qsize(2) > 0 || cycle < allowed || rd_q.size() > 0 ||
            word_q.size() > 0) && budget > 0) begin
      run(1);
      budget--;
    end
    run(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bank_read_scheduler.md
Name: bank_read_scheduler

Overview:
- Read-side controller for one packet memory bank; the bank's write side is divided into three per-source address regions.
- Each region has its own descriptor FIFO; each entry is {extra_byte[1:0], end_adr, start_adr}.
- The block picks a ready descriptor round-robin, walks the bank read address from start to end with region wrap-around, and drives bank read enable/address.
- It realigns returned RAM words into a framed TX stream with SOF/EOF and releases the region's frame when reading completes.

Parameters:
- pDEPTH_RAM, 4605, total bank words (3 x pREGION_SIZE).
- pREGION_SIZE, 1535, words per source region; region s spans [s*pREGION_SIZE, s*pREGION_SIZE+pREGION_SIZE-1].
- pRD_LAT, 2, cycles from o_en_read/o_adr_out to valid i_mem_data (bank input register + SRAM).
- pADR_W, $clog2(pDEPTH_RAM), address width (13).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_desc_empty  in  3  per-source descriptor FIFO empty; show-ahead FIFO, so data is valid while not empty.
- i_desc_data  in  3*(2*pADR_W+2)  descriptors; source s occupies slice s; fields per slice {extra[1:0], end, start}.
- o_desc_pop  out  3  one-cycle pop strobe to the granted FIFO.
- i_tx_ready  in  1  TX MAC can accept a whole frame; sampled only at frame start.
- o_adr_out  out  pADR_W  bank read address.
- o_en_read  out  1  bank read enable.
- i_mem_data  in  32  bank read data.
- o_data  out  32  TX word.
- o_valid  out  1  o_data valid.
- o_sof  out  1  first word of frame.
- o_eof  out  1  last word of frame.
- o_extra_byte  out  2  descriptor extra field, valid with o_eof.
- o_rel  out  3  one-cycle release pulse for the source region whose frame was fully read.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (i_reset=0, async): FSM=IDLE; RR pointer=0; every output 0, including the delay-pipeline contents.
  - A frame in progress when reset asserts is abandoned; its popped descriptor is lost. This is accepted behaviour.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - Condition to start: i_tx_ready=1 and at least one i_desc_empty[s]=0.
  - Grant: first non-empty source searching ptr, ptr+1, ptr+2 (mod 3).
  - Same cycle: o_desc_pop[g]=1; latch start/end/extra/g; cur<=start; ptr<=(g+1) mod 3; go READ.
  - No grant while i_tx_ready=0.
- READ, every cycle:
  - o_en_read=1, o_adr_out=cur.
  - First READ cycle is tagged sof.
  - Next address: if cur==region_top(g) then cur<=region_base(g), else cur<=cur+1.
  - When cur==end: tag eof, pulse o_rel[g] this cycle, go DRAIN.
  - start==end gives a one-word frame: sof and eof are tagged in the same cycle.
  - Frame length is not checked. Region size bounds it by construction.
- DRAIN: wait pRD_LAT cycles so the last word emerges, then go IDLE. No overlap with the next frame; the minimum inter-frame gap is pRD_LAT+1 cycles.
- Output alignment:
  - The {en_read, sof, eof} tags go through a pRD_LAT-deep shift register.
  - o_valid/o_sof/o_eof are the delayed tags.
  - o_data = i_mem_data, registered or passed through so that it aligns with o_valid exactly pRD_LAT cycles after the issuing o_en_read.
  - o_extra_byte = latched extra when o_eof=1, else 0.
- Addresses never leave the granted region. Descriptors with start/end outside the region are a protocol violation and their behaviour is undefined.
- o_desc_pop is never asserted to an empty FIFO, and at most one bit is set per cycle.

Test Plan:
- Src0 descriptor {extra=2, end=13, start=10}, tx_ready=1:
  - o_desc_pop=001 once; o_adr_out=10,11,12,13 with o_en_read on 4 consecutive cycles; o_rel=001 on the addr-13 cycle.
  - o_valid on 4 words, the first exactly 2 cycles after the first read; o_sof on word0; o_eof with o_extra_byte=2 on word3.
- Src1 wrap, {end=1536, start=3068}: addresses 3068,3069,1535,1536; 4 valid words.
- Src2 single word, start=end=3071: one read; o_sof and o_eof on the same valid cycle; o_rel=100.
- Round-robin:
  - All three FIFOs hold 2 descriptors: grant order 0,1,2,0,1,2.
  - Only src1 and src2 non-empty with ptr=0: grant 1, then 2.
- tx_ready=0 with non-empty FIFOs: no pop, o_en_read=0, o_busy=0 indefinitely. Raising tx_ready starts the grant next edge.
- Reset asserted during READ of a 6-word frame: all outputs 0 immediately (async); after release, FSM idle and the next descriptor from ptr=0 is served normally.
